// File: rtl/mem_responder.sv
// Single-port word memory behind a level-handshake request FSM with registered read data.
// Define MEM_WAIT_EN to add a WAIT state that stretches every access by WAIT_CYCLES edges.
module mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clock_i,
  input  logic                  clear_i,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  output logic [DATA_WIDTH-1:0] mdatain_o,
  output logic                  mem_done_o,
  output logic                  busy_o,
  output logic                  err_out_o
);

  // state    | meaning
  // S_IDLE   | waiting for exactly one of read/write
  // S_ACCESS | request latched; operands frozen
  // S_WAIT   | extra access cycles (MEM_WAIT_EN only)
  // S_DONE   | completion pulse cycle
  // S_HOLD   | waiting for requester to drop its request
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
`ifdef MEM_WAIT_EN
    S_WAIT   = 3'd2,
`endif
    S_DONE   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    wr_q;
  logic [DATA_WIDTH-1:0]   mdata_q;
  logic                    done_q;
  logic                    err_q;
  logic                    accept;
  logic                    conflict;
  logic                    complete;

  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

`ifdef MEM_WAIT_EN
  logic [2:0]              cnt_q, cnt_d;
`else
  logic                    unused_wait_cfg;
  assign unused_wait_cfg = ^WAIT_CYCLES;
`endif

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    conflict = 1'b0;
    complete = 1'b0;
`ifdef MEM_WAIT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (read_i ^ write_i) begin
          accept  = 1'b1;
          state_d = S_ACCESS;
        end else if (read_i && write_i) begin
          conflict = 1'b1;
        end
      end
      S_ACCESS: begin
`ifdef MEM_WAIT_EN
        state_d = S_WAIT;
        cnt_d   = 3'(WAIT_CYCLES - 1);
`else
        complete = 1'b1;
        state_d  = S_DONE;
`endif
      end
`ifdef MEM_WAIT_EN
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          complete = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
`endif
      S_DONE: state_d = S_HOLD;
      S_HOLD: begin
        if (!read_i && !write_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!clear_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      mdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_WAIT_EN
      cnt_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= complete;
      err_q   <= err_q | conflict;
`ifdef MEM_WAIT_EN
      cnt_q   <= cnt_d;
`endif
      if (accept) begin
        addr_q  <= address_i;
        wdata_q <= data_in_i;
        wr_q    <= write_i;
      end
      if (complete && !wr_q) mdata_q <= mem[addr_q];
    end
  end

  // Array is not reset; a reset edge must still suppress a pending store.
  always_ff @(posedge clock_i) begin
    if (clear_i && complete && wr_q) mem[addr_q] <= wdata_q;
  end

  assign mdatain_o  = mdata_q;
  assign mem_done_o = done_q;
  assign busy_o     = (state_q != S_IDLE);
  assign err_out_o  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder; latency expectation follows MEM_WAIT_EN.
module tb_mem_responder;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int WC = 2;
`ifdef MEM_WAIT_EN
  localparam int LAT = 1 + WC;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          clear;
  logic          rd;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] mdata;
  logic          done;
  logic          busy;
  logic          err;

  int total = 0;
  int bad   = 0;

  mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(WC)) dut (
    .clock_i   (clk),
    .clear_i   (clear),
    .read_i    (rd),
    .write_i   (wr),
    .address_i (addr),
    .data_in_i (din),
    .mdatain_o (mdata),
    .mem_done_o(done),
    .busy_o    (busy),
    .err_out_o (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full handshake: raise request, wait for MemDone, drop request, return to IDLE.
  task automatic op(input string tag, input logic is_wr, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, output int lat);
    int n;
    addr = a;
    din  = d;
    wr   = is_wr;
    rd   = ~is_wr;
    n    = 0;
    while (n < 20) begin
      tick();
      n++;
      if (done) break;
    end
    lat = n - 1;
    if (!done) chk({tag, "_timeout"}, 32'(done), 32'd1);
    rd = 1'b0;
    wr = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int lat;
    int pulses;
    clear = 1'b0;
    rd    = 1'b1;
    wr    = 1'b0;
    addr  = '0;
    din   = '0;

    tick();
    tick();
    chk("rst_mdata", mdata, 32'h0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_err",   32'(err),  32'd0);
    rd = 1'b0;
    clear = 1'b1;
    tick();

    op("wr0", 1'b1, 9'h000, 32'h30918000, lat);
    chk("wr0_lat", 32'(lat), 32'(LAT));
    op("rd0", 1'b0, 9'h000, 32'h0, lat);
    chk("rd0_lat", 32'(lat), 32'(LAT));
    chk("rd0_data", mdata, 32'h30918000);

    addr = 9'h000;
    rd = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) begin
        pulses++;
        break;
      end
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("held_pulses", 32'(pulses), 32'd1);
    chk("held_busy", 32'(busy), 32'd1);
    rd = 1'b0;
    tick();
    chk("held_idle", 32'(busy), 32'd0);

    op("wr13", 1'b1, 9'h013, 32'h00000013, lat);
    chk("wr_keeps_mdata", mdata, 32'h30918000);

    addr = 9'h012;
    din  = 32'h00000014;
    wr   = 1'b1;
    tick();
    addr = 9'h013;
    din  = 32'hDEADBEEF;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      tick();
    end
    chk("chg_done", 32'(done), 32'd1);
    wr = 1'b0;
    tick();
    tick();
    op("rd12", 1'b0, 9'h012, 32'h0, lat);
    chk("chg_rd12", mdata, 32'h00000014);
    op("rd13", 1'b0, 9'h013, 32'h0, lat);
    chk("chg_rd13", mdata, 32'h00000013);

    rd = 1'b1;
    wr = 1'b1;
    tick();
    chk("cfl_err",  32'(err),  32'd1);
    chk("cfl_busy", 32'(busy), 32'd0);
    chk("cfl_done", 32'(done), 32'd0);
    tick();
    chk("cfl_busy2", 32'(busy), 32'd0);
    rd = 1'b0;
    wr = 1'b0;
    tick();
    op("rd_after_cfl", 1'b0, 9'h012, 32'h0, lat);
    chk("cfl_sticky", 32'(err), 32'd1);

    op("wr18", 1'b1, 9'h018, 32'h00000018, lat);
    addr = 9'h018;
    din  = 32'hFFFFFFFF;
    wr   = 1'b1;
    tick();
    chk("abt_busy_acc", 32'(busy), 32'd1);
    clear = 1'b0;
    tick();
    chk("abt_done", 32'(done), 32'd0);
    chk("abt_busy", 32'(busy), 32'd0);
    chk("abt_err",  32'(err),  32'd0);
    wr = 1'b0;
    clear = 1'b1;
    tick();
    chk("abt_done2", 32'(done), 32'd0);
    op("rd18", 1'b0, 9'h018, 32'h0, lat);
    chk("abt_rd18", mdata, 32'h00000018);

    op("wr1ff", 1'b1, 9'h1FF, 32'hA5A5A5A5, lat);
    op("rd1ff", 1'b0, 9'h1FF, 32'h0, lat);
    chk("top_addr", mdata, 32'hA5A5A5A5);
    op("rd0b", 1'b0, 9'h000, 32'h0, lat);
    chk("no_wrap", mdata, 32'h30918000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
